// File: rtl/dm_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dm_access_ctrl_if
//  Description : Bundles the MEM-stage request side and the data-memory side
//                of the data-memory access controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dm_access_ctrl_if;
    // MEM-stage request side
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic        exc;
    logic [4:0]  exccode;
    logic [31:0] rdata_word;
    logic [1:0]  addr_lo;
    // Data-memory side
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // Controller view
    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata,
        input  mem_rdata, mem_ack,
        output stall, done, exc, exccode, rdata_word, addr_lo,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Pipeline / memory-model view
    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata,
        output mem_rdata, mem_ack,
        input  stall, done, exc, exccode, rdata_word, addr_lo,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dm_access_ctrl
//  Description : Data-memory access controller. Checks alignment, builds byte
//                enables and lane-replicated store data, runs the memory
//                handshake with a bus timeout, and reports a one-cycle done
//                pulse with optional address/bus exception.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  wire logic         clk,
    input  wire logic         reset,
    dm_access_ctrl_if.slave   bus
);

    localparam logic [7:0] C_TIMEOUT  = 8'(TIMEOUT);
    localparam logic [4:0] C_EXC_ADEL = 5'd4;
    localparam logic [4:0] C_EXC_ADES = 5'd5;
    localparam logic [4:0] C_EXC_BUS  = 5'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        done_q, done_d;
    logic        exc_q, exc_d;
    logic [4:0]  exccode_q, exccode_d;

    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Decode access size: type[1:0] 00 byte, 01 half, 11 word; unsigned only for byte/half
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = bus.req_wdata;
        case (bus.req_type[1:0])
            2'b00: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << bus.req_addr[1:0];
                w_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_legal = ~bus.req_addr[0];
                w_be    = 4'b0011 << bus.req_addr[1:0];
                w_wdata = {2{bus.req_wdata[15:0]}};
            end
            2'b11: begin
                w_legal = ~bus.req_type[2] && (bus.req_addr[1:0] == 2'b00);
                w_be    = 4'b1111;
                w_wdata = bus.req_wdata;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        addr_lo_d   = addr_lo_q;
        done_d      = 1'b0;
        exc_d       = 1'b0;
        exccode_d   = 5'd0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (bus.req_valid) begin
                    addr_lo_d = bus.req_addr[1:0];
                    if (w_legal) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_be_d    = w_be;
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_wdata_d = w_wdata;
                        state_d     = ACCESS;
                    end else begin
                        done_d    = 1'b1;
                        exc_d     = 1'b1;
                        exccode_d = bus.req_we ? C_EXC_ADES : C_EXC_ADEL;
                        state_d   = RESP;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                // Ack is checked first so it wins over a coincident timeout
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    done_d  = 1'b1;
                    state_d = RESP;
                end else if (cnt_d == C_TIMEOUT) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    exc_d     = 1'b1;
                    exccode_d = C_EXC_BUS;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'b0000;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            addr_lo_q   <= 2'b00;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
            exccode_q   <= 5'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            addr_lo_q   <= addr_lo_d;
            done_q      <= done_d;
            exc_q       <= exc_d;
            exccode_q   <= exccode_d;
        end
    end

    assign bus.stall      = bus.req_valid & ~done_q;
    assign bus.done       = done_q;
    assign bus.exc        = exc_q;
    assign bus.exccode    = exccode_q;
    assign bus.rdata_word = rdata_q;
    assign bus.addr_lo    = addr_lo_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_access_ctrl
//  Description : Directed self-checking bench for dm_access_ctrl (TIMEOUT=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_access_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    dm_access_ctrl_if bus ();

    dm_access_ctrl #(.TIMEOUT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_type  = 3'b000;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
    endtask

    task automatic issue(input logic we, input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_type  = t;
        bus.req_addr  = a;
        bus.req_wdata = wd;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.done, bus.exc} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.mem_req, bus.mem_we, bus.done, bus.exc});
        end
        n_cmp++;
        if ({bus.mem_be, bus.exccode, bus.addr_lo} !== 11'd0) begin
            n_fail++; $display("FAIL reset_fields: got be=%h code=%h lo=%h want 0", bus.mem_be, bus.exccode, bus.addr_lo);
        end
        n_cmp++;
        if ({bus.rdata_word, bus.mem_addr, bus.mem_wdata} !== 96'd0) begin
            n_fail++; $display("FAIL reset_words: got r=%h a=%h w=%h want 0", bus.rdata_word, bus.mem_addr, bus.mem_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw();
        issue(1'b0, 3'b011, 32'h0000_1004, 32'd0);
        #1;
        n_cmp++;
        if (bus.stall !== 1'b1) begin
            n_fail++; $display("FAIL lw_stall_c0: got %b want 1", bus.stall);
        end
        @(negedge clk);                      // cycle 1
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b10_1111 || bus.mem_addr !== 32'h0000_1004) begin
            n_fail++; $display("FAIL lw_mem_c1: got req=%b we=%b be=%b a=%h want 1 0 1111 00001004",
                               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);                      // cycle 2
        bus.mem_ack   = 1'b0;
        n_cmp++;
        if ({bus.done, bus.exc, bus.mem_req, bus.stall} !== 4'b1000) begin
            n_fail++; $display("FAIL lw_done_c2: got done,exc,req,stall=%b want 1000", {bus.done, bus.exc, bus.mem_req, bus.stall});
        end
        n_cmp++;
        if (bus.rdata_word !== 32'hDEAD_BEEF || bus.addr_lo !== 2'b00) begin
            n_fail++; $display("FAIL lw_data: got %h lo=%b want deadbeef 00", bus.rdata_word, bus.addr_lo);
        end
        idle_inputs();
        @(negedge clk);
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL lw_done_pulse: got %b want 0", bus.done);
        end
    endtask

    task automatic test_sb();
        issue(1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5);
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b11_1000 || bus.mem_wdata !== 32'hA5A5_A5A5 ||
            bus.mem_addr !== 32'd0) begin
            n_fail++; $display("FAIL sb_mem: got req=%b we=%b be=%b wd=%h a=%h want 1 1 1000 a5a5a5a5 0",
                               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_cmp++;
        if ({bus.done, bus.exc} !== 2'b10 || bus.rdata_word !== 32'hDEAD_BEEF || bus.addr_lo !== 2'b11) begin
            n_fail++; $display("FAIL sb_done: got done=%b exc=%b r=%h lo=%b want 1 0 deadbeef 11",
                               bus.done, bus.exc, bus.rdata_word, bus.addr_lo);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_misaligned();
        logic [2:0]  types [3] = '{3'b001, 3'b011, 3'b010};
        logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] addrs [3] = '{32'h1, 32'h2, 32'h0};
        logic [4:0]  codes [3] = '{5'd4, 5'd5, 5'd4};
        for (int i = 0; i < 3; i++) begin
            issue(wes[i], types[i], addrs[i], 32'hFFFF_FFFF);
            @(negedge clk);
            n_cmp++;
            if ({bus.mem_req, bus.done, bus.exc} !== 3'b011 || bus.exccode !== codes[i]) begin
                n_fail++; $display("FAIL misalign_%0d: got req=%b done=%b exc=%b code=%0d want 0 1 1 %0d",
                                   i, bus.mem_req, bus.done, bus.exc, bus.exccode, codes[i]);
            end
            idle_inputs();
            @(negedge clk);
            n_cmp++;
            if ({bus.done, bus.exc, bus.exccode, bus.mem_req} !== 8'd0) begin
                n_fail++; $display("FAIL misalign_clear_%0d: got done=%b exc=%b code=%0d req=%b want 0",
                                   i, bus.done, bus.exc, bus.exccode, bus.mem_req);
            end
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int guard = 0;
        issue(1'b0, 3'b011, 32'h0000_0020, 32'd0);
        @(negedge clk);
        while (bus.done !== 1'b1 && guard < 20) begin
            if (bus.mem_req === 1'b1) req_cycles++;
            guard++;
            @(negedge clk);
        end
        n_cmp++;
        if (guard >= 20) begin
            n_fail++; $display("FAIL timeout_wait: got no done within 20 cycles want done");
        end
        n_cmp++;
        if (req_cycles != 3) begin
            n_fail++; $display("FAIL timeout_req_cycles: got %0d want 3", req_cycles);
        end
        n_cmp++;
        if ({bus.exc, bus.exccode, bus.mem_req} !== {1'b1, 5'd7, 1'b0}) begin
            n_fail++; $display("FAIL timeout_exc: got exc=%b code=%0d req=%b want 1 7 0", bus.exc, bus.exccode, bus.mem_req);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_ack_at_timeout();
        issue(1'b0, 3'b011, 32'h0000_0040, 32'd0);
        repeat (3) @(negedge clk);           // third ACCESS cycle
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_cmp++;
        if ({bus.done, bus.exc, bus.exccode} !== {1'b1, 1'b0, 5'd0} || bus.rdata_word !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL ack_at_timeout: got done=%b exc=%b code=%0d r=%h want 1 0 0 cafef00d",
                               bus.done, bus.exc, bus.exccode, bus.rdata_word);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 3'b101, 32'h0000_0102, 32'd0);  // lhu
        @(negedge clk);
        n_cmp++;
        if (bus.mem_be !== 4'b1100 || bus.mem_addr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL b2b_lhu_be: got be=%b a=%h want 1100 00000100", bus.mem_be, bus.mem_addr);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h8765_4321;
        @(negedge clk);                      // RESP
        bus.mem_ack = 1'b0;
        n_cmp++;
        if (bus.done !== 1'b1 || bus.addr_lo !== 2'b10 || bus.rdata_word !== 32'h8765_4321) begin
            n_fail++; $display("FAIL b2b_first: got done=%b lo=%b r=%h want 1 10 87654321", bus.done, bus.addr_lo, bus.rdata_word);
        end
        issue(1'b1, 3'b001, 32'h0000_0200, 32'hFFFF_1234);   // sh, next instruction
        @(negedge clk);                      // IDLE accept
        n_cmp++;
        if (bus.done !== 1'b0 || bus.stall !== 1'b1) begin
            n_fail++; $display("FAIL b2b_accept: got done=%b stall=%b want 0 1", bus.done, bus.stall);
        end
        @(negedge clk);                      // ACCESS
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'b11_0011 || bus.mem_wdata !== 32'h1234_1234) begin
            n_fail++; $display("FAIL b2b_sh_mem: got req=%b we=%b be=%b wd=%h want 1 1 0011 12341234",
                               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_cmp++;
        if ({bus.done, bus.exc} !== 2'b10) begin
            n_fail++; $display("FAIL b2b_second_done: got done=%b exc=%b want 1 0", bus.done, bus.exc);
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int done_seen = 0;
        issue(1'b0, 3'b011, 32'h0000_0300, 32'd0);
        @(negedge clk);                      // first ACCESS cycle
        @(negedge clk);                      // second ACCESS cycle
        n_cmp++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++; $display("FAIL abort_pre: got req=%b want 1", bus.mem_req);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.done, bus.exc, bus.mem_be, bus.addr_lo} !== 10'd0 ||
            {bus.mem_addr, bus.rdata_word, bus.mem_wdata} !== 96'd0) begin
            n_fail++; $display("FAIL abort_reset: got req=%b done=%b be=%b a=%h r=%h want all 0",
                               bus.mem_req, bus.done, bus.mem_be, bus.mem_addr, bus.rdata_word);
        end
        reset = 1'b0;
        idle_inputs();
        bus.mem_ack = 1'b1;                  // stray ack outside ACCESS
        repeat (4) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.mem_req === 1'b1) done_seen++;
        end
        bus.mem_ack = 1'b0;
        n_cmp++;
        if (done_seen != 0) begin
            n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", done_seen);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_lw();
        test_sb();
        test_misaligned();
        test_timeout();
        test_ack_at_timeout();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles in ACCESS awaiting mem_ack; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  MEM stage requests a data-memory access; held until done.
REQ-005 req_we  in  1  1 = store, 0 = load.
REQ-006 req_type  in  3  000 byte signed / sb, 001 half signed / sh, 011 word / sw, 100 byte unsigned, 101 half unsigned.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data, right-justified.
REQ-009 stall  out  1  freeze pipeline at and before MEM.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 exc  out  1  request ended in exception; valid only with done.
REQ-012 exccode  out  5  4 AdEL, 5 AdES, 7 bus timeout; 0 when exc=0.
REQ-013 rdata_word  out  32  raw memory word for loads, fed to the load-extension unit.
REQ-014 addr_lo  out  2  latched req_addr[1:0], fed to the load-extension unit.
REQ-015 mem_req  out  1  memory request, held until ack or timeout.
REQ-016 mem_we  out  1  memory write strobe, qualified by mem_req.
REQ-017 mem_be  out  4  byte enables.
REQ-018 mem_addr  out  32  {req_addr[31:2], 2'b00}.
REQ-019 mem_wdata  out  32  store data shifted into lane position.
REQ-020 mem_rdata  in  32  memory read word, valid with mem_ack.
REQ-021 mem_ack  in  1  memory completion, one cycle.

Function
REQ-022 FSM states IDLE, ACCESS, RESP; all outputs except stall registered.
REQ-023 stall = req_valid & ~done, combinational.
REQ-024 IDLE, req_valid=1, request legal -> latch request, drive mem_*, enter ACCESS next cycle.
REQ-025 Misaligned request (half with addr[0]=1; word with addr[1:0]!=0) or undefined req_type -> no mem_req; enter RESP with exc=1, exccode 4 (load) or 5 (store).
REQ-026 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads also drive the type's mask.
REQ-027 mem_wdata: byte -> req_wdata[7:0] replicated on all four lanes; half -> req_wdata[15:0] replicated on both halves; word -> req_wdata unchanged.
REQ-028 ACCESS: mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata held stable; 8-bit wait counter increments each cycle.
REQ-029 ACCESS with mem_ack=1 -> capture mem_rdata into rdata_word (loads only; stores leave rdata_word unchanged), drop mem_req, enter RESP.
REQ-030 ACCESS, counter reaches TIMEOUT without mem_ack -> drop mem_req, enter RESP with exc=1, exccode 7.
REQ-031 Simultaneous mem_ack and timeout in one cycle -> ack wins, no exception.
REQ-032 RESP: done=1 for exactly one cycle, then IDLE; exc/exccode valid that cycle only.
REQ-033 mem_ack outside ACCESS is ignored.
REQ-034 Minimum latency: accept cycle 0, mem_req cycles 1..n, done the cycle after ack; zero-wait memory -> done in cycle 2.
REQ-035 Back-to-back: req_valid still high in the IDLE cycle after RESP starts a new access.

Reset
REQ-036 reset=1 -> state IDLE, counter 0, mem_req/mem_we/done/exc 0, mem_be 0, exccode 0, rdata_word 0, addr_lo 0, mem_addr 0, mem_wdata 0.
REQ-037 Reset during ACCESS aborts: mem_req deasserts in the following cycle; no done pulse is produced.

Verification
REQ-038 lw addr 0x0000_1004, ack on first ACCESS cycle, mem_rdata 0xDEADBEEF -> mem_be 1111, done in cycle 2, rdata_word 0xDEADBEEF, addr_lo 00.
REQ-039 sb addr 0x0000_0003, wdata 0x0000_00A5 -> mem_be 1000, mem_wdata 0xA5A5A5A5, mem_addr 0x0000_0000, done with exc=0.
REQ-040 lh addr 0x0000_0001 -> no mem_req, done with exc=1, exccode 4; sw addr 0x0000_0002 -> exccode 5.
REQ-041 TIMEOUT=3, lw, mem_ack never asserted -> mem_req high 3 cycles, then done with exc=1, exccode 7.
REQ-042 mem_ack asserted in the same cycle the counter reaches TIMEOUT -> done with exc=0, data captured.
REQ-043 reset asserted on the 2nd ACCESS cycle -> next cycle all outputs at reset values; no done pulse.
